ibex_mem_arbiter: RTL and testbench
===================================

# ibex_mem_arbiter

Two-host, one-bus arbiter that merges the core's instruction-fetch and load/store request ports onto a single req/gnt/rvalid memory port, for single-bus SoC integrations. Tracks the source of every outstanding transaction in order and steers each response strobe back to its originating host. Sits between the core's memory ports and the system interconnect. Response data, integrity and error are broadcast from the bus to both hosts; only the rvalid strobes are routed.

## Interface
- MaxOutstanding, 2: maximum accepted-but-unanswered bus transactions (≥1).
- clk_i  input  1  clock.
- rst_ni  input  1  reset, synchronous, active-low.
- instr_req_i  input  1  fetch request, held stable until granted.
- instr_addr_i  input  32  fetch word address.
- instr_gnt_o  output  1  fetch address phase accepted.
- instr_rvalid_o  output  1  fetch response valid.
- data_req_i  input  1  LSU request, held stable until granted.
- data_pkt_i  input  ibex_arb_pkt_t  LSU we, be[3:0], addr[31:0], wdata[31:0], wdata_intg[6:0].
- data_gnt_o  output  1  LSU address phase accepted.
- data_rvalid_o  output  1  LSU response valid.
- bus_req_o  output  1  bus request.
- bus_pkt_o  output  ibex_arb_pkt_t  bus request payload; fetches drive we=0, be=4'hF, wdata/intg=0.
- bus_gnt_i  input  1  bus address phase accepted.
- bus_rvalid_i  input  1  bus response valid, in-order.
- busy_o  output  1  one or more transactions outstanding.
- spurious_rsp_o  output  1  one-cycle pulse: bus_rvalid_i while nothing outstanding.

## Operation
- Winner chosen combinationally among requesting hosts; bus_req_o = winner req AND NOT full; bus_pkt_o muxed from winner.
- Grant: host gnt = bus_gnt_i AND bus_req_o AND (winner == host). Loser sees gnt=0.
- Lock: bus_req_o=1 with bus_gnt_i=0 sets lock_q and latches winner; while locked, winner is forced to latched source (payload stable until gnt). Lock clears on gnt.
- Source FIFO (depth MaxOutstanding, 1 bit): push winner on bus_req_o AND bus_gnt_i; pop on bus_rvalid_i; head steers rvalid to instr_rvalid_o or data_rvalid_o.
- Full: occupancy == MaxOutstanding blocks bus_req_o even if bus_rvalid_i pops the same cycle (no rvalid→req path).
- Simultaneous push and pop: occupancy unchanged, order preserved.
- Empty + bus_rvalid_i: both host rvalids stay 0, spurious_rsp_o pulses, occupancy stays 0.
- Default priority fixed: data over instr.
- Occupancy counter width $clog2(MaxOutstanding+1); never wraps.

## Timing
- Zero-cycle combinational paths: host req→bus_req_o, bus_gnt_i→host gnt, bus_rvalid_i→host rvalid.
- Arbitration adds no latency; back-to-back grants every cycle until full.
- Reset (rst_ni low at clk edge): FIFO empty, lock_q=0, RR pointer=instr-last; while rst_ni low, bus_req_o, instr_gnt_o, data_gnt_o, host rvalids, spurious_rsp_o forced 0; busy_o=0 the cycle after.
- Reset mid-transaction discards outstanding sources; responses arriving afterward flag spurious_rsp_o.

## Configuration
- IBEX_MEM_ARB_RR_EN defined: round-robin; last_q records last granted source, on contention the other host wins; last_q updates only on grant; lock still overrides.
- Undefined: fixed data-over-instr priority, no last_q register.

## Structure
- ibex_arb_pkg: ibex_arb_pkt_t, arb_src_e {ArbSrcInstr, ArbSrcData}, fetch-default payload constant.
- Sub-module ibex_arb_src_fifo: parameterised-depth, 1-bit, push/pop/full/empty/head, sync active-low reset.

## Test plan
- Data only, 3 reads, gnt immediate, rvalid 1 cycle later each → data_gnt_o 3 pulses, data_rvalid_o 3 pulses, instr_rvalid_o 0.
- Both request same cycle, fixed priority, bus_gnt_i=1 → data granted first, instr next cycle; rvalids return data then instr.
- Instr requests, bus_gnt_i low 3 cycles, data_req_i rises cycle 1 → bus_pkt_o stays fetch addr until gnt; data granted after.
- Two granted, no rvalid → third request blocked (bus_req_o=0); bus_rvalid_i frees slot, request issues next cycle.
- bus_rvalid_i with empty FIFO → spurious_rsp_o=1 one cycle, no host rvalid; rst_ni low with 2 outstanding → busy_o=0 after.
- IBEX_MEM_ARB_RR_EN, both requesting continuously → grants alternate instr/data each cycle.

Source files
------------

// File: rtl/ibex_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_arb_pkg
// Description : Shared types for the two-host memory arbiter: the bus request
//               payload, the source tag and the payload a fetch drives.
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_arb_pkg;

    // Request payload carried from a host to the bus
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [6:0]  wdata_intg;
    } ibex_arb_pkt_t;

    // Originating host of a transaction
    typedef enum logic {
        ArbSrcInstr = 1'b0,
        ArbSrcData  = 1'b1
    } arb_src_e;

    // Fetches are full-word reads with no write data
    localparam ibex_arb_pkt_t ArbFetchDefault = '{
        we:         1'b0,
        be:         4'hF,
        addr:       32'h0,
        wdata:      32'h0,
        wdata_intg: 7'h0
    };

    // Build the bus payload for a fetch of the given address
    function automatic ibex_arb_pkt_t arb_fetch_pkt(input logic [31:0] addr);
        ibex_arb_pkt_t pkt;
        pkt      = ArbFetchDefault;
        pkt.addr = addr;
        return pkt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_arb_src_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ibex_arb_src_fifo
// Description : In-order record of which host owns each outstanding bus
//               transaction. One tag per entry, parameterised depth.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_arb_src_fifo
    import ibex_arb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  arb_src_e data_i,
    input  logic     pop_i,
    output logic     full_o,
    output logic     empty_o,
    output arb_src_e head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    arb_src_e        mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            push_en;
    logic            pop_en;

    // Pointers wrap explicitly so non-power-of-two depths work
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntFull);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];

    // A push into a full FIFO or a pop from an empty one is ignored
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    // Next pointer and occupancy; push+pop together leaves occupancy unchanged
    always_comb begin
        wptr_d = push_en ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop_en ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (push_en && !pop_en) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_en && !push_en) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Tag storage, written at the tail on an accepted push
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= ArbSrcInstr;
            end
        end else if (push_en) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ibex_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ibex_mem_arbiter
// Description : Merges the fetch and load/store request ports onto a single
//               req/gnt/rvalid bus. Tracks the source of each outstanding
//               transaction and steers rvalid back to its originating host.
//               Response data/error are broadcast outside this block.
// Options     : IBEX_MEM_ARB_RR_EN - round-robin arbitration on contention;
//               when undefined, data has fixed priority over instr.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_mem_arbiter
    import ibex_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,

    input  logic          data_req_i,
    input  ibex_arb_pkt_t data_pkt_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,

    output logic          bus_req_o,
    output ibex_arb_pkt_t bus_pkt_o,
    input  logic          bus_gnt_i,
    input  logic          bus_rvalid_i,

    output logic          busy_o,
    output logic          spurious_rsp_o
);

    arb_src_e winner;
    arb_src_e lock_src_q, lock_src_d;
    logic     lock_q, lock_d;
    logic     winner_req;
    logic     fifo_full;
    logic     fifo_empty;
    arb_src_e fifo_head;
    logic     push;
    logic     pop;

`ifdef IBEX_MEM_ARB_RR_EN
    arb_src_e last_q, last_d;
`endif

    // Pick the winning host; an unanswered request keeps ownership of the bus
    always_comb begin
        winner = ArbSrcInstr;
        if (lock_q) begin
            winner = lock_src_q;
        end else if (data_req_i && instr_req_i) begin
`ifdef IBEX_MEM_ARB_RR_EN
            winner = (last_q == ArbSrcData) ? ArbSrcInstr : ArbSrcData;
`else
            winner = ArbSrcData;
`endif
        end else if (data_req_i) begin
            winner = ArbSrcData;
        end
    end

    assign winner_req = (winner == ArbSrcData) ? data_req_i : instr_req_i;

    // Full depends only on registered occupancy, so rvalid never reaches req
    assign bus_req_o = rst_ni & winner_req & ~fifo_full;
    assign bus_pkt_o = (winner == ArbSrcData) ? data_pkt_i
                                              : arb_fetch_pkt(instr_addr_i);

    assign push        = bus_req_o & bus_gnt_i;
    assign instr_gnt_o = push & (winner == ArbSrcInstr);
    assign data_gnt_o  = push & (winner == ArbSrcData);

    // Responses retire the oldest outstanding tag; with none pending they are flagged
    assign pop            = rst_ni & bus_rvalid_i & ~fifo_empty;
    assign instr_rvalid_o = pop & (fifo_head == ArbSrcInstr);
    assign data_rvalid_o  = pop & (fifo_head == ArbSrcData);
    assign spurious_rsp_o = rst_ni & bus_rvalid_i & fifo_empty;
    assign busy_o         = ~fifo_empty;

    // Lock next-state: set on a stalled request, released on grant
    always_comb begin
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        if (bus_req_o && !bus_gnt_i) begin
            lock_d     = 1'b1;
            lock_src_d = winner;
        end else if (bus_req_o && bus_gnt_i) begin
            lock_d = 1'b0;
        end
    end

    // Lock state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_src_q <= ArbSrcInstr;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end

`ifdef IBEX_MEM_ARB_RR_EN
    // Round-robin pointer follows the most recently granted host
    always_comb begin
        last_d = push ? winner : last_q;
    end

    // Round-robin pointer register, instr counted as last after reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= ArbSrcInstr;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    ibex_arb_src_fifo #(
        .Depth (MaxOutstanding)
    ) u_src_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (winner),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_ibex_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_mem_arbiter
// Description : Directed self-checking bench for ibex_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_mem_arbiter;
    import ibex_arb_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          instr_req;
    logic [31:0]   instr_addr;
    logic          instr_gnt;
    logic          instr_rvalid;
    logic          data_req;
    ibex_arb_pkt_t data_pkt;
    logic          data_gnt;
    logic          data_rvalid;
    logic          bus_req;
    ibex_arb_pkt_t bus_pkt;
    logic          bus_gnt;
    logic          bus_rvalid;
    logic          busy;
    logic          spurious;

    int n_tests;
    int n_fail;

    ibex_mem_arbiter #(
        .MaxOutstanding (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .data_req_i     (data_req),
        .data_pkt_i     (data_pkt),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .bus_req_o      (bus_req),
        .bus_pkt_o      (bus_pkt),
        .bus_gnt_i      (bus_gnt),
        .bus_rvalid_i   (bus_rvalid),
        .busy_o         (busy),
        .spurious_rsp_o (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; returns 2 time units after the rising edge
    task automatic next();
        @(posedge clk);
        #2;
    endtask

    function automatic ibex_arb_pkt_t mk_pkt(input logic we, input logic [31:0] addr);
        ibex_arb_pkt_t p;
        p.we         = we;
        p.be         = 4'b0011;
        p.addr       = addr;
        p.wdata      = addr ^ 32'hA5A5_0000;
        p.wdata_intg = 7'h2B;
        return p;
    endfunction

    function automatic ibex_arb_pkt_t fetch_exp(input logic [31:0] addr);
        ibex_arb_pkt_t p;
        p.we         = 1'b0;
        p.be         = 4'hF;
        p.addr       = addr;
        p.wdata      = 32'h0;
        p.wdata_intg = 7'h0;
        return p;
    endfunction

    task automatic idle_inputs();
        instr_req  = 1'b0;
        instr_addr = 32'h0;
        data_req   = 1'b0;
        data_pkt   = '0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        instr_req  = 1'b1;
        instr_addr = 32'h40;
        data_req   = 1'b1;
        data_pkt   = mk_pkt(1'b1, 32'h80);
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        #1;
        n_tests++;
        if ({bus_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid, spurious} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {bus_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid, spurious});
        end
        next();
        next();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        idle_inputs();
        rst_n = 1'b1;
        next();
    endtask

    task automatic test_data_only();
        int gnts, drv, irv;
        gnts = 0; drv = 0; irv = 0;
        for (int i = 0; i < 4; i++) begin
            data_req   = (i < 3);
            data_pkt   = mk_pkt(1'b0, 32'h1000 + 32'(4 * i));
            bus_gnt    = (i < 3);
            bus_rvalid = (i > 0);
            #1;
            if (i < 3) begin
                n_tests++;
                if (bus_pkt !== data_pkt) begin
                    n_fail++;
                    $display("FAIL data_only_pkt[%0d]: got %h want %h", i, bus_pkt, data_pkt);
                end
            end
            gnts += int'(data_gnt);
            drv  += int'(data_rvalid);
            irv  += int'(instr_rvalid);
            next();
        end
        idle_inputs();
        #1;
        n_tests++;
        if (gnts != 3) begin
            n_fail++;
            $display("FAIL data_only_gnt_count: got %0d want 3", gnts);
        end
        n_tests++;
        if (drv != 3) begin
            n_fail++;
            $display("FAIL data_only_rvalid_count: got %0d want 3", drv);
        end
        n_tests++;
        if (irv != 0) begin
            n_fail++;
            $display("FAIL data_only_instr_rvalid: got %0d want 0", irv);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL data_only_busy_end: got %b want 0", busy);
        end
        next();
    endtask

`ifndef IBEX_MEM_ARB_RR_EN
    task automatic test_fixed_priority();
        instr_req  = 1'b1;
        instr_addr = 32'h200;
        data_req   = 1'b1;
        data_pkt   = mk_pkt(1'b1, 32'h300);
        bus_gnt    = 1'b1;
        #1;
        n_tests++;
        if ({data_gnt, instr_gnt} !== 2'b10 || bus_pkt !== data_pkt) begin
            n_fail++;
            $display("FAIL prio_first: got gnt d/i %b%b pkt %h want 10 pkt %h",
                     data_gnt, instr_gnt, bus_pkt, data_pkt);
        end
        next();
        data_req = 1'b0;
        #1;
        n_tests++;
        if ({data_gnt, instr_gnt} !== 2'b01 || bus_pkt !== fetch_exp(32'h200)) begin
            n_fail++;
            $display("FAIL prio_second: got gnt d/i %b%b pkt %h want 01 pkt %h",
                     data_gnt, instr_gnt, bus_pkt, fetch_exp(32'h200));
        end
        next();
        idle_inputs();
        bus_rvalid = 1'b1;
        #1;
        n_tests++;
        if ({data_rvalid, instr_rvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL prio_rvalid1: got d/i %b%b want 10", data_rvalid, instr_rvalid);
        end
        next();
        #1;
        n_tests++;
        if ({data_rvalid, instr_rvalid} !== 2'b01) begin
            n_fail++;
            $display("FAIL prio_rvalid2: got d/i %b%b want 01", data_rvalid, instr_rvalid);
        end
        next();
        idle_inputs();
    endtask
`endif

    task automatic test_lock();
        instr_req  = 1'b1;
        instr_addr = 32'h500;
        bus_gnt    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            data_req = (c >= 1);
            data_pkt = mk_pkt(1'b1, 32'h600);
            #1;
            n_tests++;
            if (bus_req !== 1'b1 || bus_pkt !== fetch_exp(32'h500) || {data_gnt, instr_gnt} !== 2'b00) begin
                n_fail++;
                $display("FAIL lock_hold[%0d]: got req %b pkt %h gnt d/i %b%b want 1 pkt %h 00",
                         c, bus_req, bus_pkt, data_gnt, instr_gnt, fetch_exp(32'h500));
            end
            next();
        end
        bus_gnt = 1'b1;
        #1;
        n_tests++;
        if ({data_gnt, instr_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL lock_release: got gnt d/i %b%b want 01", data_gnt, instr_gnt);
        end
        next();
        instr_req = 1'b0;
        #1;
        n_tests++;
        if ({data_gnt, instr_gnt} !== 2'b10 || bus_pkt !== mk_pkt(1'b1, 32'h600)) begin
            n_fail++;
            $display("FAIL lock_data_after: got gnt d/i %b%b pkt %h want 10", data_gnt, instr_gnt, bus_pkt);
        end
        next();
        idle_inputs();
        bus_rvalid = 1'b1;
        #1;
        n_tests++;
        if ({data_rvalid, instr_rvalid} !== 2'b01) begin
            n_fail++;
            $display("FAIL lock_rvalid1: got d/i %b%b want 01", data_rvalid, instr_rvalid);
        end
        next();
        #1;
        n_tests++;
        if ({data_rvalid, instr_rvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL lock_rvalid2: got d/i %b%b want 10", data_rvalid, instr_rvalid);
        end
        next();
        idle_inputs();
    endtask

    task automatic test_full();
        data_req = 1'b1;
        data_pkt = mk_pkt(1'b0, 32'h700);
        bus_gnt  = 1'b1;
        next();
        next();
        #1;
        n_tests++;
        if (bus_req !== 1'b0 || data_gnt !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full_block: got req %b gnt %b busy %b want 0 0 1", bus_req, data_gnt, busy);
        end
        next();
        bus_rvalid = 1'b1;
        #1;
        n_tests++;
        if (bus_req !== 1'b0 || data_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop_same_cycle: got req %b rvalid %b want 0 1", bus_req, data_rvalid);
        end
        next();
        bus_rvalid = 1'b0;
        #1;
        n_tests++;
        if (bus_req !== 1'b1 || data_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL full_reissue: got req %b gnt %b want 1 1", bus_req, data_gnt);
        end
        next();
        idle_inputs();
        bus_rvalid = 1'b1;
        next();
        next();
        idle_inputs();
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain_busy: got %b want 0", busy);
        end
        next();
    endtask

    task automatic test_spurious_and_reset();
        bus_rvalid = 1'b1;
        #1;
        n_tests++;
        if (spurious !== 1'b1 || {data_rvalid, instr_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL spurious_pulse: got sp %b rv d/i %b%b want 1 00", spurious, data_rvalid, instr_rvalid);
        end
        next();
        bus_rvalid = 1'b0;
        #1;
        n_tests++;
        if (spurious !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_clear: got sp %b busy %b want 0 0", spurious, busy);
        end
        data_req = 1'b1;
        data_pkt = mk_pkt(1'b0, 32'h900);
        bus_gnt  = 1'b1;
        next();
        next();
        idle_inputs();
        #1;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy_before: got %b want 1", busy);
        end
        rst_n = 1'b0;
        next();
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_busy_after: got %b want 0", busy);
        end
        rst_n      = 1'b1;
        bus_rvalid = 1'b1;
        #1;
        n_tests++;
        if (spurious !== 1'b1 || data_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_late_rsp: got sp %b rv %b want 1 0", spurious, data_rvalid);
        end
        next();
        idle_inputs();
    endtask

`ifdef IBEX_MEM_ARB_RR_EN
    task automatic test_round_robin();
        instr_req  = 1'b1;
        instr_addr = 32'hA00;
        data_req   = 1'b1;
        data_pkt   = mk_pkt(1'b1, 32'hB00);
        bus_gnt    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus_rvalid = (c > 0);
            #1;
            n_tests++;
            if ({data_gnt, instr_gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_alternate[%0d]: got gnt d/i %b%b want %b", c, data_gnt, instr_gnt,
                         (c % 2 == 0) ? 2'b10 : 2'b01);
            end
            next();
        end
        idle_inputs();
        bus_rvalid = 1'b1;
        next();
        idle_inputs();
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        rst_n = 1'b0;
        #2;
        test_reset();
        test_data_only();
`ifndef IBEX_MEM_ARB_RR_EN
        test_fixed_priority();
`endif
        test_lock();
        test_full();
        test_spurious_and_reset();
`ifdef IBEX_MEM_ARB_RR_EN
        test_round_robin();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
